spike_rate_decoder: RTL and testbench
=====================================

// Module: spike_rate_decoder
// PURPOSE
// - Output-layer decoder and consumer of the LIF neuron spike/membrane stream.
// - Counts spikes per output neuron over one NUM_TIMESTEPS inference window.
// - Picks the winning action by argmax of spike count. Ties go to the higher final membrane,
//   then to the lower index.
// - Sits between the output LIF layer and the cartpole action interface. Issues one
//   action_valid pulse per inference.
// PARAMETERS
// - NUM_NEURONS    2    output neurons / actions (>=2)
// - NUM_TIMESTEPS  30   valid beats per inference window
// - MEM_WIDTH      24   signed membrane width, QS2.13 with headroom
// PORTS
// - clk            in   1                      clock, rising edge
// - reset          in   1                      asynchronous, active-high
// - start          in   1                      clear counters, arm a new window
// - spike_valid    in   1                      one beat = one timestep of all neurons
// - spikes         in   NUM_NEURONS            spike bit per neuron for this beat
// - membrane       in   NUM_NEURONS*MEM_WIDTH  flattened signed membranes; neuron i at [i*MEM_WIDTH +: MEM_WIDTH]
// - spike_count    out  NUM_NEURONS*CW         flattened counts, CW=$clog2(NUM_TIMESTEPS+1)
// - action         out  $clog2(NUM_NEURONS)    winning neuron index
// - action_valid   out  1                      one-cycle pulse, result ready
// - busy           out  1                      high in ACCUM and SCAN
// - overrun        out  1                      sticky: beat arrived while not in ACCUM after a window was armed
// BEHAVIOUR
// - Reset values: every count 0, action 0, action_valid 0, busy 0, overrun 0.
//   Internal: state IDLE, beat counter 0, scan index 0.
// - FSM states: IDLE, ACCUM, SCAN, DONE.
//   - IDLE -> ACCUM on start.
//   - ACCUM -> SCAN on the edge that accepts beat NUM_TIMESTEPS-1.
//   - SCAN -> DONE after NUM_NEURONS scan cycles.
//   - DONE -> ACCUM on start. DONE holds otherwise.
// - start in any state:
//   - Zero all counts, the beat counter, overrun and the stored membranes.
//   - Go to ACCUM. busy rises the next cycle.
//   - A spike_valid on the same cycle as start is discarded and not counted.
// - ACCUM, for each spike_valid beat:
//   - count[i] += spikes[i]. Counts saturate at NUM_TIMESTEPS (unreachable in legal use).
//   - membrane[i] is captured only on beat NUM_TIMESTEPS-1 (final membrane).
//   - Beat counter 0..NUM_TIMESTEPS-1. No wrap; it leaves ACCUM instead.
// - SCAN, one neuron compared per cycle, index 0..NUM_NEURONS-1:
//   - Candidate i replaces the best if count[i] > best_count, or
//     if count[i] == best_count and mem[i] > best_mem (signed).
//   - Equal count and equal mem keeps the lower index.
//   - Index 0 seeds best unconditionally.
// - Latency: action_valid is high exactly NUM_NEURONS+1 cycles after the edge accepting the
//   last beat. action is updated on the same edge.
// - DONE: action and spike_count held stable until the next start. action_valid is low.
// - spike_valid in SCAN or DONE:
//   - Ignored; counts do not change.
//   - Sets overrun, which stays set until start or reset.
// - spike_valid in IDLE (no window armed since reset): ignored, overrun not set.
// - Reset mid-window: everything returns to reset values immediately; no action_valid is
//   produced.
// - spike_count is live: it tracks accumulation during ACCUM.
// STRUCTURE
// - snn_pkg shared package:
//   - QS2.13 constants (FRAC_BITS=13, ONE=8192) and MEM_WIDTH default.
//   - typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} dec_state_t.
//   - Function count_width(n) = $clog2(n+1).
// - One sub-module, spike_counter: per-neuron saturating counter with clear and inc inputs.
//   Instantiated NUM_NEURONS times in a generate loop.
// - Argmax compare and FSM stay in this module. No multipliers.
// TESTING
// - Basic window:
//   - Stimulus: start, then 30 beats with neuron0 spiking every 3rd beat, neuron1 every beat.
//   - Expected: counts 10/30, action=1, action_valid pulse 3 cycles after the last beat edge,
//     busy low in DONE.
// - Count tie:
//   - Stimulus: both neurons spike 15x; final membranes 0x000800 and 0x001000.
//   - Expected: action=1. With equal membranes, action=0.
// - Negative membrane tie:
//   - Stimulus: counts 0/0, membranes -8192 and -4096.
//   - Expected: action=1 (signed compare).
// - Restart mid-window:
//   - Stimulus: start, 12 beats all-ones, start again with a simultaneous spike_valid,
//     then 30 zero beats.
//   - Expected: counts 0/0, action=0, exactly one action_valid pulse.
// - Overrun:
//   - Stimulus: a 31st beat during SCAN, and another in DONE.
//   - Expected: counts unchanged, overrun=1 until the next start clears it.
// - Async reset:
//   - Stimulus: reset asserted at beat 20 between clock edges.
//   - Expected: all outputs 0 immediately; no action_valid after deassert until a new start
//     plus 30 beats.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared SNN definitions: QS2.13 fixed-point constants, decoder state encoding and width helpers.
// Pure declarations; no logic or latency.
// No flow control here.
package snn_pkg;

  localparam int FRAC_BITS         = 13;
  localparam int ONE               = 1 << FRAC_BITS;
  localparam int DEFAULT_MEM_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } dec_state_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spike_counter.sv
// Per-neuron spike counter: clear wins over inc, saturates at MAX.
// Count updates one cycle after inc/clear.
// No backpressure; inc is ignored at saturation.
module spike_counter #(
  parameter int W   = 5,
  parameter int MAX = 30
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  // Saturating count with synchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX_C)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Output-layer decoder: counts spikes per neuron over one window, argmax by count then membrane.
// action_valid pulses NUM_NEURONS+1 cycles after the edge accepting the last beat.
// No backpressure: beats outside ACCUM are dropped and flagged via sticky overrun.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int  NUM_NEURONS   = 2,
  parameter int  NUM_TIMESTEPS = 30,
  parameter int  MEM_WIDTH     = DEFAULT_MEM_WIDTH,
  localparam int CW            = count_width(NUM_TIMESTEPS),
  localparam int AW            = $clog2(NUM_NEURONS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           spike_valid,
  input  logic [NUM_NEURONS-1:0]         spikes,
  input  logic [NUM_NEURONS*MEM_WIDTH-1:0] membrane,
  output logic [NUM_NEURONS*CW-1:0]      spike_count,
  output logic [AW-1:0]                  action,
  output logic                           action_valid,
  output logic                           busy,
  output logic                           overrun
);

  localparam int            BW        = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_TIMESTEPS - 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_NEURONS - 1);

  dec_state_t state, next_state;

  logic [BW-1:0]                beat_cnt;
  logic [AW-1:0]                scan_idx;
  logic [CW-1:0]                cnt   [NUM_NEURONS];
  logic signed [MEM_WIDTH-1:0]  mem_q [NUM_NEURONS];
  logic [CW-1:0]                best_count;
  logic signed [MEM_WIDTH-1:0]  best_mem;
  logic [AW-1:0]                best_idx;
  logic                         finish;

  // A beat coinciding with start belongs to no window and is discarded.
  logic accept, last_beat, scan_last, take;
  logic [CW-1:0]               cand_count;
  logic signed [MEM_WIDTH-1:0] cand_mem;

  assign accept     = spike_valid && !start && (state == ACCUM);
  assign last_beat  = accept && (beat_cnt == LAST_BEAT);
  assign scan_last  = (state == SCAN) && (scan_idx == LAST_IDX);
  assign cand_count = cnt[scan_idx];
  assign cand_mem   = mem_q[scan_idx];
  // Strictly greater count wins; equal count falls back to signed membrane; full tie keeps lower index.
  assign take       = (scan_idx == '0) || (cand_count > best_count) ||
                      ((cand_count == best_count) && (cand_mem > best_mem));

  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_cnt
    spike_counter #(
      .W   (CW),
      .MAX (NUM_TIMESTEPS)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (start),
      .inc   (accept && spikes[gi]),
      .count (cnt[gi])
    );
    assign spike_count[gi*CW +: CW] = cnt[gi];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // FSM next-state: start re-arms from any state; DONE and IDLE otherwise hold.
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (last_beat) next_state = SCAN;
        SCAN:    if (scan_last) next_state = DONE;
        default: next_state = state;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    busy = (state == ACCUM) || (state == SCAN);
  end

  // Beat counting, final-membrane capture, sequential argmax and result publication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt     <= '0;
      scan_idx     <= '0;
      best_count   <= '0;
      best_mem     <= '0;
      best_idx     <= '0;
      finish       <= 1'b0;
      action       <= '0;
      action_valid <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) mem_q[i] <= '0;
    end else begin
      action_valid <= 1'b0;
      if (start) begin
        beat_cnt <= '0;
        scan_idx <= '0;
        finish   <= 1'b0;
        overrun  <= 1'b0;
        for (int i = 0; i < NUM_NEURONS; i++) mem_q[i] <= '0;
      end else begin
        if (accept) begin
          beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
          if (last_beat) begin
            for (int i = 0; i < NUM_NEURONS; i++)
              mem_q[i] <= membrane[i*MEM_WIDTH +: MEM_WIDTH];
          end
        end
        if (spike_valid && ((state == SCAN) || (state == DONE))) overrun <= 1'b1;
        if (state == SCAN) begin
          if (take) begin
            best_count <= cand_count;
            best_mem   <= cand_mem;
            best_idx   <= scan_idx;
          end
          scan_idx <= scan_last ? '0 : scan_idx + 1'b1;
          finish   <= scan_last;
        end
        // One register stage after the last compare publishes the winner.
        if (finish) begin
          finish       <= 1'b0;
          action       <= best_idx;
          action_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: table vectors, randomized windows, corner sequences.
module tb_spike_rate_decoder;

  localparam int N  = 2;
  localparam int T  = 30;
  localparam int MW = 24;
  localparam int CW = 5;
  localparam int AW = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              spike_valid;
  logic [N-1:0]      spikes;
  logic [N*MW-1:0]   membrane;
  logic [N*CW-1:0]   spike_count;
  logic [AW-1:0]     action;
  logic              action_valid;
  logic              busy;
  logic              overrun;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  spike_rate_decoder #(
    .NUM_NEURONS   (N),
    .NUM_TIMESTEPS (T),
    .MEM_WIDTH     (MW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .spike_valid  (spike_valid),
    .spikes       (spikes),
    .membrane     (membrane),
    .spike_count  (spike_count),
    .action       (action),
    .action_valid (action_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (action_valid) pulses++;

  // Window stimulus shared by the model and the driver.
  logic [N-1:0]          pat [T];
  logic signed [MW-1:0]  fm  [N];

  typedef struct {
    int per0;
    int per1;
    int m0;
    int m1;
    int ex_act;
    int ex_c0;
    int ex_c1;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [N-1:0] s, input logic signed [MW-1:0] m0,
                      input logic signed [MW-1:0] m1);
    spike_valid = 1'b1;
    spikes      = s;
    membrane    = {m1, m0};
    tick();
    spike_valid = 1'b0;
    spikes      = '0;
  endtask

  function automatic logic [31:0] cnt_out(input int i);
    return 32'(spike_count[i*CW +: CW]);
  endfunction

  // Reference: count of spikes of neuron i over the first nb beats of pat.
  function automatic int ref_count(input int i, input int nb);
    int s = 0;
    for (int b = 0; b < nb; b++) s += int'(pat[b][i]);
    return s;
  endfunction

  // Reference argmax: highest count, then highest final membrane, then lowest index.
  function automatic int ref_winner();
    int    bc = -1;
    longint bm = -(64'sd1 <<< 40);
    int    w  = 0;
    for (int i = 0; i < N; i++) if (ref_count(i, T) > bc) bc = ref_count(i, T);
    for (int i = 0; i < N; i++)
      if (ref_count(i, T) == bc && longint'(fm[i]) > bm) bm = longint'(fm[i]);
    for (int i = N - 1; i >= 0; i--)
      if (ref_count(i, T) == bc && longint'(fm[i]) == bm) w = i;
    return w;
  endfunction

  task automatic wait_pulse(input string tag, output int w);
    w = 0;
    while (!action_valid && w < 20) begin
      tick();
      w++;
    end
    if (!action_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no action_valid within 20 cycles", tag);
    end
  endtask

  task automatic run_window(input string tag, input int ea, input int ec0, input int ec1);
    int w;
    do_start();
    chk({tag, "_busy_armed"}, 32'(busy), 32'd1);
    for (int b = 0; b < T; b++) begin
      if (b == T - 1) beat(pat[b], fm[0], fm[1]);
      else            beat(pat[b], MW'($urandom), MW'($urandom));
      if (b == 14) chk({tag, "_live_c0"}, cnt_out(0), 32'(ref_count(0, 15)));
    end
    chk({tag, "_av_early"}, 32'(action_valid), 32'd0);
    wait_pulse(tag, w);
    chk({tag, "_latency"}, 32'(w), 32'(N + 1));
    chk({tag, "_action"}, 32'(action), 32'(ea));
    chk({tag, "_c0"}, cnt_out(0), 32'(ec0));
    chk({tag, "_c1"}, cnt_out(1), 32'(ec1));
    tick();
    chk({tag, "_av_pulse_end"}, 32'(action_valid), 32'd0);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_action_held"}, 32'(action), 32'(ea));
  endtask

  task automatic load_tbl(input int k);
    for (int b = 0; b < T; b++) begin
      pat[b][0] = (tbl[k].per0 != 0) && (b % tbl[k].per0 == 0);
      pat[b][1] = (tbl[k].per1 != 0) && (b % tbl[k].per1 == 0);
    end
    fm[0] = MW'(tbl[k].m0);
    fm[1] = MW'(tbl[k].m1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int w;

    tbl[0] = '{per0: 3, per1: 1, m0: 0,       m1: 0,       ex_act: 1, ex_c0: 10, ex_c1: 30};
    tbl[1] = '{per0: 2, per1: 2, m0: 'h800,   m1: 'h1000,  ex_act: 1, ex_c0: 15, ex_c1: 15};
    tbl[2] = '{per0: 2, per1: 2, m0: 'h1000,  m1: 'h1000,  ex_act: 0, ex_c0: 15, ex_c1: 15};
    tbl[3] = '{per0: 0, per1: 0, m0: -8192,   m1: -4096,   ex_act: 1, ex_c0: 0,  ex_c1: 0};
    tbl[4] = '{per0: 1, per1: 0, m0: 0,       m1: 5000,    ex_act: 0, ex_c0: 30, ex_c1: 0};
    tbl[5] = '{per0: 2, per1: 3, m0: 100,     m1: -100,    ex_act: 0, ex_c0: 15, ex_c1: 10};

    reset       = 1'b1;
    start       = 1'b0;
    spike_valid = 1'b0;
    spikes      = '0;
    membrane    = '0;
    tick();
    tick();
    chk("rst_c0", cnt_out(0), 32'd0);
    chk("rst_c1", cnt_out(1), 32'd0);
    chk("rst_action", 32'(action), 32'd0);
    chk("rst_av", 32'(action_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick();

    // Beat before any window is armed: ignored, no overrun.
    beat(2'b11, 24'sd0, 24'sd0);
    chk("idle_overrun", 32'(overrun), 32'd0);
    chk("idle_c0", cnt_out(0), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int k = 0; k < 6; k++) begin
      load_tbl(k);
      run_window($sformatf("tbl%0d", k), tbl[k].ex_act, tbl[k].ex_c0, tbl[k].ex_c1);
    end

    for (int r = 0; r < 8; r++) begin
      logic mirror;
      mirror = 1'($urandom_range(0, 1));
      for (int b = 0; b < T; b++) begin
        pat[b] = N'($urandom_range(0, 3));
        if (mirror) pat[b][1] = pat[b][0];
      end
      for (int i = 0; i < N; i++) fm[i] = MW'((int'($urandom_range(0, 2)) - 1) * 8192);
      run_window($sformatf("rnd%0d", r), ref_winner(), ref_count(0, T), ref_count(1, T));
    end
    chk("pulse_total", 32'(pulses), 32'd14);

    // Restart mid-window with a simultaneous beat that must be discarded.
    load_tbl(0);
    run_window("pre_restart", 1, 10, 30);
    p0 = pulses;
    do_start();
    for (int b = 0; b < 12; b++) beat(2'b11, 24'sd0, 24'sd0);
    chk("restart_mid_c0", cnt_out(0), 32'd12);
    start       = 1'b1;
    spike_valid = 1'b1;
    spikes      = 2'b11;
    tick();
    start       = 1'b0;
    spike_valid = 1'b0;
    spikes      = '0;
    chk("restart_discard_c0", cnt_out(0), 32'd0);
    chk("restart_discard_c1", cnt_out(1), 32'd0);
    for (int b = 0; b < T; b++) beat(2'b00, 24'sd0, 24'sd0);
    wait_pulse("restart", w);
    chk("restart_latency", 32'(w), 32'(N + 1));
    chk("restart_action", 32'(action), 32'd0);
    chk("restart_c0", cnt_out(0), 32'd0);
    chk("restart_c1", cnt_out(1), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("restart_one_pulse", 32'(pulses - p0), 32'd1);

    // Overrun: extra beats in SCAN and DONE.
    load_tbl(0);
    do_start();
    for (int b = 0; b < T; b++) beat(pat[b], fm[0], fm[1]);
    beat(2'b11, 24'sd0, 24'sd0);
    chk("ovr_scan_flag", 32'(overrun), 32'd1);
    chk("ovr_scan_c0", cnt_out(0), 32'd10);
    chk("ovr_scan_c1", cnt_out(1), 32'd30);
    wait_pulse("ovr", w);
    chk("ovr_action", 32'(action), 32'd1);
    tick();
    beat(2'b11, 24'sd0, 24'sd0);
    chk("ovr_done_flag", 32'(overrun), 32'd1);
    chk("ovr_done_c0", cnt_out(0), 32'd10);
    chk("ovr_done_c1", cnt_out(1), 32'd30);
    for (int i = 0; i < 3; i++) tick();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    do_start();
    chk("ovr_cleared", 32'(overrun), 32'd0);
    chk("ovr_start_c1", cnt_out(1), 32'd0);

    // Async reset at beat 20, between clock edges.
    for (int b = 0; b < 20; b++) beat(2'b11, 24'sd0, 24'sd0);
    chk("arst_pre_c0", cnt_out(0), 32'd20);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_c0", cnt_out(0), 32'd0);
    chk("arst_c1", cnt_out(1), 32'd0);
    chk("arst_action", 32'(action), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_av", 32'(action_valid), 32'd0);
    #2;
    reset = 1'b0;
    p0 = pulses;
    for (int b = 0; b < 10; b++) beat(2'b11, 24'sd0, 24'sd0);
    for (int i = 0; i < 10; i++) tick();
    chk("arst_no_pulse", 32'(pulses - p0), 32'd0);
    chk("arst_idle_c0", cnt_out(0), 32'd0);
    chk("arst_idle_overrun", 32'(overrun), 32'd0);
    load_tbl(0);
    run_window("post_arst", 1, 10, 30);
    chk("post_arst_pulses", 32'(pulses - p0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
